// File: rtl/redirect_ctrl.sv
// MEM-stage redirect controller: turns an M-stage redirect request into a fetch PC
// override plus pipeline flushes, holding the target while fetch is stalled.
// Optional build macro REDIR_ALIGN_CHK_EN: misaligned targets raise adel_req instead of redirecting.
module redirect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_chk,
  input  logic [31:0] M_NPC,
  input  logic        M_valid,
  input  logic        F_stall,
  input  logic        exc_req,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        flush_FD,
  output logic        flush_DE,
  output logic        flush_EM,
  output logic        redir_busy,
`ifdef REDIR_ALIGN_CHK_EN
  output logic        adel_req,
  output logic [31:0] adel_addr,
`endif
  output logic        state_dbg
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] tgt_q;
  logic        accept, latch_tgt;
  logic        rv_c, ffd_c, fde_c, fem_c;
  logic [31:0] pc_c;
`ifdef REDIR_ALIGN_CHK_EN
  logic        adel_c;
  logic [31:0] adel_addr_c;
`endif

  // Handshake: a request is taken only in IDLE with M_valid & M_chk and no exception;
  // redir_valid means F loads redir_pc at the next edge, no back-pressure beyond F_stall.
  assign accept = (state == IDLE) && M_valid && M_chk && !exc_req;

  always_comb begin
    state_nxt = state;
    rv_c      = 1'b0;
    pc_c      = 32'h0;
    ffd_c     = 1'b0;
    fde_c     = 1'b0;
    fem_c     = 1'b0;
    latch_tgt = 1'b0;
`ifdef REDIR_ALIGN_CHK_EN
    adel_c      = 1'b0;
    adel_addr_c = 32'h0;
`endif
    if (exc_req) begin
      // Exception wins: drop everything, abandon any pending redirect.
      state_nxt = IDLE;
    end else if (state == PEND) begin
      rv_c  = 1'b1;
      pc_c  = tgt_q;
      ffd_c = 1'b1;
      if (!F_stall) state_nxt = IDLE;
    end else if (accept) begin
      ffd_c = 1'b1;
      fde_c = 1'b1;
      fem_c = 1'b1;
`ifdef REDIR_ALIGN_CHK_EN
      if (M_NPC[1:0] != 2'b00) begin
        adel_c      = 1'b1;
        adel_addr_c = M_NPC;
      end else begin
        rv_c = 1'b1;
        pc_c = M_NPC;
        if (F_stall) begin
          state_nxt = PEND;
          latch_tgt = 1'b1;
        end
      end
`else
      rv_c = 1'b1;
      pc_c = {M_NPC[31:2], 2'b00};
      if (F_stall) begin
        state_nxt = PEND;
        latch_tgt = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tgt_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (latch_tgt) tgt_q <= pc_c;
    end
  end

  // Outputs are combinational from inputs, so gate them with reset directly.
  assign redir_valid = reset & rv_c;
  assign redir_pc    = reset ? pc_c : 32'h0;
  assign flush_FD    = reset & ffd_c;
  assign flush_DE    = reset & fde_c;
  assign flush_EM    = reset & fem_c;
  assign redir_busy  = reset & (state == PEND);
  assign state_dbg   = (state == PEND);
`ifdef REDIR_ALIGN_CHK_EN
  assign adel_req    = reset & adel_c;
  assign adel_addr   = reset ? adel_addr_c : 32'h0;
`endif

endmodule
